// File: rtl/spi_regbank_pkg.sv
// rtl/spi_regbank_pkg.sv - shared constants and types for the SPI register bank
package spi_regbank_pkg;

    // Command byte layout: [7] RW (1=write), [6] SPACE (0=config, 1=status), [5:0] ADDR
    localparam int CMD_W     = 8;
    localparam int RW_BIT    = 7;
    localparam int SPACE_BIT = 6;
    localparam int ADDR_W    = 6;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    // Field order mirrors the bit positions above so a byte can be cast directly.
    typedef struct packed {
        logic              rw;
        logic              space;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - SPI pin synchronisers and spi_clk edge pulses
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   spi_cs_n/clk/mosi    raw asynchronous SPI pins
//   cs_n_s, mosi_s       2-flop synchronised chip select and data
//   sclk_rise/sclk_fall  1-clk pulses on synchronised spi_clk edges
//
// Synchronisers reset to 0 so a chip select that is low across a reset is
// never mistaken for a fresh high-then-low sequence.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic spi_cs_n,
    input  logic spi_clk,
    input  logic spi_mosi,
    output logic cs_n_s,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [1:0] cs_ff;
    logic [1:0] mosi_ff;
    logic [2:0] sclk_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_ff   <= '0;
            mosi_ff <= '0;
            sclk_ff <= '0;
        end else begin
            cs_ff   <= {cs_ff[0], spi_cs_n};
            mosi_ff <= {mosi_ff[0], spi_mosi};
            sclk_ff <= {sclk_ff[1:0], spi_clk};
        end
    end

    assign cs_n_s    = cs_ff[1];
    assign mosi_s    = mosi_ff[1];
    // sclk_ff[1] is the synchronised level, sclk_ff[2] its previous value
    assign sclk_rise = sclk_ff[1] & ~sclk_ff[2];
    assign sclk_fall = ~sclk_ff[1] & sclk_ff[2];

endmodule

// File: rtl/spi_regbank.sv
// rtl/spi_regbank.sv - SPI mode-0 slave with config and status register banks
//
// Ports:
//   clk, rst      system clock (>= 4x spi_clk), synchronous active-high reset
//   ena           block enable; low ignores SPI and forces spi_miso=0
//   spi_cs_n      chip select, active low (async)
//   spi_clk       SPI clock, mode 0 (async)
//   spi_mosi      serial data in, MSB first
//   spi_miso      serial data out, MSB first
//   config_regs   flattened config registers, reg i at [i*WIDTH +: WIDTH]
//   status_regs   flattened status inputs, same packing
//   cfg_wr_stb    1-clk pulse per committed config write
//   cfg_wr_addr   address of the committed write
//   frame_err     1-clk pulse when CS deasserts mid-word
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter int                          NUM_CFG    = 8,
    parameter int                          NUM_STATUS = 8,
    parameter int                          WIDTH      = 8,
    parameter logic [NUM_CFG*WIDTH-1:0]    CFG_RST    = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic                           spi_cs_n,
    input  logic                           spi_clk,
    input  logic                           spi_mosi,
    output logic                           spi_miso,
    output logic [NUM_CFG*WIDTH-1:0]       config_regs,
    input  logic [NUM_STATUS*WIDTH-1:0]    status_regs,
    output logic                           cfg_wr_stb,
    output logic [ADDR_W-1:0]              cfg_wr_addr,
    output logic                           frame_err
);

    // One receive shifter serves both the command byte and data words.
    localparam int               SR_W      = (WIDTH > CMD_W) ? WIDTH : CMD_W;
    localparam logic [5:0]       CMD_LAST  = 6'(CMD_W - 1);
    localparam logic [5:0]       WORD_LAST = 6'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] CFG_TOP  = ADDR_W'(NUM_CFG - 1);
    localparam logic [ADDR_W-1:0] STAT_TOP = ADDR_W'(NUM_STATUS - 1);

    logic              cs_n_s;
    logic              mosi_s;
    logic              sclk_rise;
    logic              sclk_fall;

    state_t            state;
    state_t            state_next;
    logic [5:0]        bit_cnt;
    logic [SR_W-2:0]   rx_sr;
    logic [SR_W-1:0]   rx_next;
    cmd_t              cmd_q;
    cmd_t              cmd_new;
    logic [WIDTH-1:0]  tx_sr;
    logic [WIDTH-1:0]  cfg_q [NUM_CFG];
    logic              armed;

    logic              leave;
    logic              abort_err;
    logic              cmd_done;
    logic              word_done;
    logic              wr_commit;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_space;
    logic [WIDTH-1:0]  rd_data;

    spi_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .spi_cs_n  (spi_cs_n),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    assign rx_next = {rx_sr, mosi_s};
    assign cmd_new = cmd_t'(rx_next[CMD_W-1:0]);

    // Burst address wraps at the top of the selected space; out-of-range
    // addresses never match the top and simply roll over at 63.
    assign addr_next = (cmd_q.addr == (cmd_q.space ? STAT_TOP : CFG_TOP))
                     ? '0 : cmd_q.addr + 1'b1;

    // A read load happens either at the end of the command byte (first word)
    // or at the end of a data word (next word of the burst).
    assign rd_space = cmd_done ? cmd_new.space : cmd_q.space;
    assign rd_addr  = cmd_done ? cmd_new.addr  : addr_next;

    always_comb begin
        rd_data = '0;
        if (rd_space) begin
            for (int i = 0; i < NUM_STATUS; i++) begin
                if (rd_addr == ADDR_W'(i)) rd_data = status_regs[i*WIDTH +: WIDTH];
            end
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (rd_addr == ADDR_W'(i)) rd_data = cfg_q[i];
            end
        end
    end

    assign wr_commit = word_done && ena && cmd_q.rw && !cmd_q.space
                     && (int'(cmd_q.addr) < NUM_CFG);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        leave      = 1'b0;
        abort_err  = 1'b0;
        cmd_done   = 1'b0;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                if (ena && !cs_n_s && armed) state_next = CMD;
            end
            CMD, DATA: begin
                if (cs_n_s || !ena) begin
                    leave      = 1'b1;
                    state_next = IDLE;
                    // Disable also ends the frame, but silently.
                    abort_err  = cs_n_s && ena && (bit_cnt != 6'd0);
                end else if (sclk_rise) begin
                    if (state == CMD && bit_cnt == CMD_LAST) begin
                        cmd_done   = 1'b1;
                        state_next = DATA;
                    end else if (state == DATA && bit_cnt == WORD_LAST) begin
                        word_done = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            rx_sr       <= '0;
            cmd_q       <= '0;
            tx_sr       <= '0;
            armed       <= 1'b0;
            cfg_wr_stb  <= 1'b0;
            cfg_wr_addr <= '0;
            frame_err   <= 1'b0;
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= CFG_RST[i*WIDTH +: WIDTH];
        end else begin
            cfg_wr_stb <= 1'b0;
            frame_err  <= abort_err;

            // A frame may only start after CS has been seen high, so a reset
            // or disable in the middle of a frame cannot resume that frame.
            if (cs_n_s)                                 armed <= 1'b1;
            else if (state == IDLE && state_next == CMD) armed <= 1'b0;

            if (state == IDLE || leave) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                rx_sr <= rx_next[SR_W-2:0];
                if (cmd_done) begin
                    bit_cnt <= '0;
                    cmd_q   <= cmd_new;
                    tx_sr   <= cmd_new.rw ? '0 : rd_data;
                end else if (word_done) begin
                    bit_cnt    <= '0;
                    cmd_q.addr <= addr_next;
                    if (!cmd_q.rw) tx_sr <= rd_data;
                    if (wr_commit) begin
                        cfg_wr_stb  <= 1'b1;
                        cfg_wr_addr <= cmd_q.addr;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end else if (sclk_fall && state == DATA && bit_cnt != 6'd0) begin
                // No shift on the fall right after a word load: the fresh MSB
                // must stay on the line for the master's next rising edge.
                tx_sr <= tx_sr << 1;
            end

            for (int i = 0; i < NUM_CFG; i++) begin
                if (wr_commit && cmd_q.addr == ADDR_W'(i)) cfg_q[i] <= rx_next[WIDTH-1:0];
            end
        end
    end

    assign spi_miso = (ena && state == DATA && !cmd_q.rw) ? tx_sr[WIDTH-1] : 1'b0;

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign config_regs[g*WIDTH +: WIDTH] = cfg_q[g];
    end

endmodule

// File: tb/tb_spi_regbank.sv
// tb/tb_spi_regbank.sv - directed self-checking bench for spi_regbank
module tb_spi_regbank;
    import spi_regbank_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic        spi_cs_n = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [63:0] config_regs;
    logic [31:0] status_regs = 32'h0;
    logic        cfg_wr_stb;
    logic [5:0]  cfg_wr_addr;
    logic        frame_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          stb_cnt = 0;
    int          err_cnt = 0;
    logic [5:0]  stb_log [64];
    logic [7:0]  rxb [3];
    int          stb_base;
    int          err_base;

    spi_regbank #(
        .NUM_CFG    (8),
        .NUM_STATUS (4),
        .WIDTH      (8),
        .CFG_RST    (64'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .spi_cs_n    (spi_cs_n),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .config_regs (config_regs),
        .status_regs (status_regs),
        .cfg_wr_stb  (cfg_wr_stb),
        .cfg_wr_addr (cfg_wr_addr),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_wr_stb) begin
            stb_log[stb_cnt[5:0]] = cfg_wr_addr;
            stb_cnt = stb_cnt + 1;
        end
        if (frame_err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // SCLK period 80 ns (8 clk periods); mosi set while sclk low, miso taken at the rise.
    task automatic spi_bits(input logic [7:0] v, input int n, output logic [7:0] r);
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = v[i];
            #40;
            r = {r[6:0], spi_miso};
            spi_clk = 1'b1;
            #40;
            spi_clk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] cmd, input int n,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] r;
        logic [7:0] d;
        spi_cs_n = 1'b0;
        #40;
        spi_bits(cmd, 8, r);
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? b0 : ((k == 1) ? b1 : b2);
            spi_bits(d, 8, r);
            rxb[k] = r;
        end
        #40;
        spi_cs_n = 1'b1;
        #200;
    endtask

    initial begin
        logic [7:0] r;
        #3;
        #50;
        check("rst_cfg",  config_regs, 64'h0);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_stb",  cfg_wr_stb, 1'b0);
        check("rst_err",  frame_err, 1'b0);
        rst = 1'b0;
        #100;

        // single write
        stb_base = stb_cnt;
        frame(8'h83, 1, 8'hA5, 8'h00, 8'h00);
        check("wr1_cfg",   config_regs, 64'h0000_0000_A500_0000);
        check("wr1_nstb",  stb_cnt - stb_base, 1);
        check("wr1_addr",  stb_log[stb_base], 6'd3);

        // burst write wrapping 7 -> 0
        stb_base = stb_cnt;
        frame(8'h86, 3, 8'h11, 8'h22, 8'h33);
        check("burst_cfg",   config_regs, 64'h2211_0000_A500_0033);
        check("burst_nstb",  stb_cnt - stb_base, 3);
        check("burst_a0",    stb_log[stb_base],     6'd6);
        check("burst_a1",    stb_log[stb_base + 1], 6'd7);
        check("burst_a2",    stb_log[stb_base + 2], 6'd0);

        // status read with auto-increment
        status_regs = 32'h4433_2211;
        frame(8'h41, 2, 8'h00, 8'h00, 8'h00);
        check("st_rd0", rxb[0], 8'h22);
        check("st_rd1", rxb[1], 8'h33);

        // config readback, out-of-range read, dropped write
        frame(8'h03, 1, 8'h00, 8'h00, 8'h00);
        check("cfg_rd3", rxb[0], 8'hA5);
        frame(8'h09, 1, 8'h00, 8'h00, 8'h00);
        check("cfg_rd9", rxb[0], 8'h00);
        stb_base = stb_cnt;
        frame(8'h89, 1, 8'hFF, 8'h00, 8'h00);
        check("oor_nstb", stb_cnt - stb_base, 0);
        check("oor_cfg",  config_regs, 64'h2211_0000_A500_0033);

        // abort mid-word
        stb_base = stb_cnt;
        err_base = err_cnt;
        spi_cs_n = 1'b0;
        #40;
        spi_bits(8'h82, 8, r);
        spi_bits(8'h0F, 4, r);
        #40;
        spi_cs_n = 1'b1;
        #200;
        check("abort_err",  err_cnt - err_base, 1);
        check("abort_nstb", stb_cnt - stb_base, 0);
        check("abort_cfg",  config_regs, 64'h2211_0000_A500_0033);
        frame(8'h82, 1, 8'h5A, 8'h00, 8'h00);
        check("post_abort_cfg",  config_regs, 64'h2211_0000_A55A_0033);
        check("post_abort_nstb", stb_cnt - stb_base, 1);
        check("post_abort_addr", stb_log[stb_base], 6'd2);
        check("post_abort_err",  err_cnt - err_base, 1);

        // reset in the middle of a data word
        stb_base = stb_cnt;
        spi_cs_n = 1'b0;
        #40;
        spi_bits(8'h84, 8, r);
        spi_bits(8'h0F, 4, r);
        rst = 1'b1;
        #30;
        check("midrst_cfg",   config_regs, 64'h0);
        check("midrst_miso",  spi_miso, 1'b0);
        check("midrst_state", 64'(int'(dut.state)), 64'(int'(IDLE)));
        rst = 1'b0;
        #20;
        spi_bits(8'h0F, 4, r);
        spi_bits(8'h66, 8, r);
        #40;
        spi_cs_n = 1'b1;
        #200;
        check("midrst_nstb",  stb_cnt - stb_base, 0);
        check("midrst_cfg2",  config_regs, 64'h0);

        // disabled block ignores a full write frame
        ena = 1'b0;
        stb_base = stb_cnt;
        frame(8'h81, 1, 8'h77, 8'h00, 8'h00);
        check("ena0_nstb", stb_cnt - stb_base, 0);
        check("ena0_cfg",  config_regs, 64'h0);
        ena = 1'b1;
        #40;
        frame(8'h81, 1, 8'h77, 8'h00, 8'h00);
        check("ena1_cfg",  config_regs, 64'h0000_0000_0000_7700);
        check("ena1_nstb", stb_cnt - stb_base, 1);
        check("ena1_addr", stb_log[stb_base], 6'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_regbank.md
Name: spi_regbank

Overview:
- Parametrised successor to the fixed 8x8 SPI config-register wrapper.
- Contains its own SPI mode-0 slave, oversampled in the `clk` domain.
- Provides NUM_CFG read/write config registers and NUM_STATUS read-only status registers in separate address spaces.
- Adds burst auto-increment, per-write strobe, parameterised reset values, and frame-abort detection.
- Sits between the chip-level SPI pins and the user logic of the project.

Parameters:
- NUM_CFG, 8, number of config registers (1..64).
- NUM_STATUS, 8, number of status registers (1..64).
- WIDTH, 8, register width in bits (1..32).
- CFG_RST, '0, NUM_CFG*WIDTH-bit reset image; register i resets to slice [i*WIDTH +: WIDTH].

Ports:
- clk  in  1  system clock; must run at least 4x spi_clk.
- rst  in  1  reset.
- ena  in  1  block enable. Low: SPI ignored, FSM held in IDLE, spi_miso=0.
- spi_cs_n  in  1  chip select, active low, asynchronous to clk.
- spi_clk  in  1  SPI clock (mode 0), asynchronous to clk.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- config_regs  out  NUM_CFG*WIDTH  flattened config registers; reg i at [i*WIDTH +: WIDTH].
- status_regs  in  NUM_STATUS*WIDTH  flattened status inputs, same packing.
- cfg_wr_stb  out  1  one-clk pulse on each committed config write.
- cfg_wr_addr  out  6  address of the committed write; valid while cfg_wr_stb=1.
- frame_err  out  1  one-clk pulse when CS deasserts mid-word.

Behaviour:
- Clock and reset: single clock `clk`, rising edge. Reset `rst` is synchronous and active-high.
- Reset values:
  - config_regs=CFG_RST.
  - spi_miso=0, cfg_wr_stb=0, cfg_wr_addr=0, frame_err=0.
  - FSM=IDLE, bit counter=0.
- Synchronisers: spi_cs_n, spi_clk and spi_mosi each pass through 2 flops. Edge detection uses a third flop on spi_clk. A detected edge is a 1-clk pulse; rise_k denotes the clk cycle in which the rise is detected.
- Frame format:
  - Command byte: bit7 RW (1=write), bit6 SPACE (0=config, 1=status), bits5:0 ADDR.
  - The command byte is followed by zero or more WIDTH-bit data words.
- FSM states:
  - IDLE: waits for synced CS low → CMD; bit counter cleared.
  - CMD: samples mosi on each rise. After the 8th bit, latches RW/SPACE/ADDR and moves to DATA. For reads, loads the shift register with the addressed register in the same cycle.
  - DATA: samples mosi on each rise. After WIDTH bits:
    - Write with SPACE=0, ADDR<NUM_CFG and ena=1: config_regs[ADDR] updated and cfg_wr_stb=1 with cfg_wr_addr=ADDR at rise_k+1.
    - ADDR then increments. It wraps to 0 after the last register of the selected space (NUM_CFG-1 or NUM_STATUS-1).
    - Reads load the next word.
  - Any state: synced CS high → IDLE next cycle.
- Read data:
  - Status words are snapshotted from status_regs at load time.
  - Out-of-range ADDR reads return 0.
  - spi_miso = shift-register MSB. On each detected falling edge in DATA with word bit count ≠0, shift left. During CMD and writes, spi_miso=0.
- Ignored writes: writes to SPACE=1 or to out-of-range ADDR are dropped, with no strobe. The burst still increments ADDR.
- Frame abort: CS high while in CMD with counter ≠0, or in DATA with counter ≠0 → frame_err=1 for one clk. The partial word is discarded and no write occurs. A CS rise on a word boundary is not an error.
- Reset mid-frame: FSM → IDLE. A new frame starts only after CS is seen high then low again.
- ena dropping mid-frame: same as an abort, but without frame_err.

Decomposition:
- spi_regbank_pkg:
  - CMD_W=8, RW_BIT=7, SPACE_BIT=6, ADDR_W=6.
  - typedef enum state_t {IDLE, CMD, DATA}.
  - typedef cmd_t (packed struct: rw, space, addr).
- Sub-module spi_sync_edge: 2-flop synchronisers plus rise/fall pulse generation for spi_clk. Used once.

Test Plan (NUM_CFG=8, NUM_STATUS=4, WIDTH=8, CFG_RST=0, clk=8x sclk):
- Single write: cmd 0x83, data 0xA5 → config_regs[31:24]=0xA5 and one cfg_wr_stb with cfg_wr_addr=3. Other registers remain 0.
- Burst write with wrap: cmd 0x86, data 0x11,0x22,0x33 → reg6=0x11, reg7=0x22, reg0=0x33. Three strobes with addresses 6,7,0.
- Status read: status_regs={8'h44,8'h33,8'h22,8'h11}, cmd 0x41 followed by 16 clocks → MISO bytes 0x22, 0x33.
- Config readback and out-of-range: after the write above, cmd 0x03 → 0xA5. Cmd 0x09 → 0x00. Write cmd 0x89, data 0xFF → no strobe, config unchanged.
- Abort: cmd 0x82, 4 data bits, then CS high → frame_err pulse, reg2 unchanged, no strobe. The next full frame works normally.
- Reset and ena:
  - rst asserted mid-DATA → config_regs=CFG_RST, spi_miso=0, FSM in IDLE.
  - ena=0 during a full write frame → no change and no strobe.
